seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//  Parametrised multiplexed 7-segment driver for sensor channels read over I2C.
//  Replaces derived-clock scanning: everything runs on one clock with enable ticks.
//  Rotates through N_CH data words, or shows one selected word. Supports hold,
//  leading-zero blanking and anti-ghost guard time. Sits between I2C master
//  result registers and board anode/segment pins.
// PARAMETERS
//  N_CH         3      number of data channels (>=1)
//  N_DIGITS     4      digits on the display; DATA_W = 4*N_DIGITS
//  SCAN_DIV     50000  clk cycles per digit slot (>= GUARD+2)
//  GUARD        16     cycles at slot start with all anodes off
//  DWELL_FRAMES 512    full scan frames per channel in auto mode (>=1)
//  SEG_ACT_LOW  1      1: seg/dp driven low = lit
//  AN_ACT_LOW   1      1: anode driven low = on
// PORTS
//  clk      in   1                   system clock
//  arstn    in   1                   async reset, active low
//  ch_data  in   N_CH*4*N_DIGITS     channel k at [k*DATA_W +: DATA_W]
//  ch_valid in   N_CH                1 = channel enabled for auto rotation
//  manual   in   1                   1 = show man_sel, 0 = auto rotate
//  man_sel  in   max(1,clog2(N_CH))  channel index in manual mode
//  hold     in   1                   freeze displayed value and channel
//  lz_blank in   1                   1 = blank leading zero digits
//  an       out  N_DIGITS            digit enables; one-hot active outside guard
//  seg      out  7                   {g,f,e,d,c,b,a}
//  dp       out  1                   decimal point
//  cur_ch   out  max(1,clog2(N_CH))  channel currently displayed
// BEHAVIOUR
//  - Reset (async, arstn=0): prescaler=0, digit=0, dwell=0, cur_ch=0, shadow=0,
//    an/seg/dp all inactive at the selected polarity. Release is synchronous.
//  - Prescaler counts 0..SCAN_DIV-1. slot_tick when it equals SCAN_DIV-1.
//    digit increments on slot_tick and wraps N_DIGITS-1 -> 0.
//    frame_end = slot_tick && digit==N_DIGITS-1.
//  - Channel select, evaluated only at frame_end:
//    manual=1: cur_ch<=man_sel; values >=N_CH select N_CH-1. ch_valid is ignored.
//      dwell<=0.
//    manual=0, hold=0: dwell++; at DWELL_FRAMES-1 dwell<=0 and cur_ch advances
//      to the next index with ch_valid=1, wrapping modulo N_CH.
//      If the current channel is the only valid one, it stays.
//    manual=0, hold=1: dwell and cur_ch frozen.
//    Current channel with ch_valid=0 in auto mode: advance at the next frame_end,
//    regardless of dwell count.
//  - Shadow register: loaded at frame_end with the word of the newly selected
//    channel, unless hold=1. No update mid-frame, so there is no tearing.
//  - No valid channel (ch_valid==0, auto mode): all digits blank; cur_ch holds.
//  - Digit output (registered; 1 clk after the prescaler/digit change):
//    nibble = shadow[digit*4 +: 4]; seg = hex font 0-F.
//    lz_blank=1: a digit is blanked if it and all higher nibbles are 0.
//      Digit 0 is never blanked.
//    dp lit on digit N_DIGITS-1 iff hold=1.
//    an: all off while prescaler < GUARD; otherwise one-hot on digit.
//  - Input changes take effect at the next frame_end only. The exception is
//    lz_blank, which acts on the next registered digit output.
//  - Reset mid-frame clears all state immediately. No partial-state recovery.
// STRUCTURE
//  - Package seg7_pkg: 16-entry hex-to-segment constant table (active-high)
//    and clog2-based width helper.
//  - Sub-module seg7_scan_timer: prescaler, digit and frame_end generation.
//  - Top: channel selector, dwell counter, shadow register, blanking, and
//    polarity-applied output registers.
// TESTING (N_CH=3, N_DIGITS=4, SCAN_DIV=4, GUARD=1, DWELL_FRAMES=2, active-low)
//  1 Reset: arstn=0 mid-slot -> an=4'hF, seg=7'h7F, dp=1 immediately;
//    cur_ch=0; after release, first an=4'hE appears 2 clks later.
//  2 Auto rotate: data ch0/1/2 = 1234/ABCD/0F00, all valid ->
//    cur_ch 0->1->2->0 every 32 clks; digit0 of ch1 shows seg for D.
//  3 Skip: ch_valid=3'b101 -> cur_ch sequence 0,2,0. Set ch_valid=0 ->
//    all digits blank, cur_ch frozen.
//  4 Hold: hold=1 while ch0 data changes 1234->5678 -> display stays 1234,
//    cur_ch frozen, dp lit on digit 3 only.
//  5 Manual: manual=1, man_sel=2 asserted mid-frame -> switch at next
//    frame_end only. man_sel=3 -> cur_ch=2.
//  6 Blanking: ch word 0007, lz_blank=1 -> digits 3..1 off, digit0 shows 7.
//    Word 0000 -> digit0 shows 0. Guard: each slot has 1 clk with an=4'hF.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package seg7_pkg;

    // Active-high hex font, one 7-bit {g,f,e,d,c,b,a} entry per nibble,
    // entry 0 in the least significant slot.
    localparam logic [16*7-1:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Segment pattern (active-high) for one hex nibble.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        return HEX_FONT[int'(nib)*7 +: 7];
    endfunction

    // Width of a counter/index for n values; never less than one bit.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Single-clock scan timebase: prescaler per digit slot, digit index and a
// frame_end strobe on the last cycle of the last digit slot.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000,
    localparam int PW  = sel_w(SCAN_DIV),
    localparam int DGW = sel_w(N_DIGITS)
) (
    input  logic           clk,
    input  logic           arstn,
    output logic [PW-1:0]  presc,
    output logic [DGW-1:0] digit,
    output logic           frame_end
);

    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DGW-1:0] DIGIT_LAST = DGW'(N_DIGITS - 1);

    logic [PW-1:0]  presc_q, presc_d;
    logic [DGW-1:0] digit_q, digit_d;
    logic           slot_tick;

    // Next prescaler/digit values and the slot/frame strobes.
    always_comb begin
        slot_tick = (presc_q == PRESC_LAST);
        frame_end = slot_tick && (digit_q == DIGIT_LAST);
        presc_d   = slot_tick ? '0 : presc_q + 1'b1;
        digit_d   = digit_q;
        if (slot_tick) begin
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
        end
    end

    // Timebase registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            presc_q <= '0;
            digit_q <= '0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
        end
    end

    assign presc = presc_q;
    assign digit = digit_q;

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment driver: picks a channel word once per frame (auto
// rotation with dwell, or manual), latches it into a shadow register so a
// frame never tears, and drives registered anode/segment/dp pins.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 16,
    parameter int DWELL_FRAMES = 512,
    parameter int SEG_ACT_LOW  = 1,
    parameter int AN_ACT_LOW   = 1,
    localparam int DATA_W = 4*N_DIGITS,
    localparam int CH_W   = sel_w(N_CH)
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [N_CH-1:0]        ch_valid,
    input  logic                   manual,
    input  logic [CH_W-1:0]        man_sel,
    input  logic                   hold,
    input  logic                   lz_blank,
    output logic [N_DIGITS-1:0]    an,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [CH_W-1:0]        cur_ch
);

    localparam int PW  = sel_w(SCAN_DIV);
    localparam int DGW = sel_w(N_DIGITS);
    localparam int DWW = sel_w(DWELL_FRAMES);

    localparam logic [PW-1:0]       GUARD_P    = PW'(GUARD);
    localparam logic [DGW-1:0]      DIGIT_LAST = DGW'(N_DIGITS - 1);
    localparam logic [DWW-1:0]      DWELL_LAST = DWW'(DWELL_FRAMES - 1);
    localparam logic [CH_W-1:0]     MAX_CH     = CH_W'(N_CH - 1);
    localparam logic [6:0]          SEG_OFF    = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_OFF     = (SEG_ACT_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_OFF     = (AN_ACT_LOW != 0) ? '1 : '0;

    logic [PW-1:0]  presc;
    logic [DGW-1:0] digit;
    logic           frame_end;

    seg7_scan_timer #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .clk       (clk),
        .arstn     (arstn),
        .presc     (presc),
        .digit     (digit),
        .frame_end (frame_end)
    );

    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic [DWW-1:0]      dwell_q, dwell_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic                blank_all_q, blank_all_d;
    logic                hold_disp_q, hold_disp_d;
    logic [N_DIGITS-1:0] an_q, an_d, an_on;
    logic [6:0]          seg_q, seg_d, seg_on;
    logic                dp_q, dp_d;
    logic [CH_W-1:0]     nxt_ch, man_ch;
    logic                found;
    logic [3:0]          nib;
    logic                upper_zero, blank;

    // First valid channel after the current one, wrapping; the current
    // channel itself is the last candidate so a lone valid channel stays.
    always_comb begin
        nxt_ch = cur_ch_q;
        found  = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!found && ch_valid[(int'(cur_ch_q) + i) % N_CH]) begin
                nxt_ch = CH_W'((int'(cur_ch_q) + i) % N_CH);
                found  = 1'b1;
            end
        end
        man_ch = (man_sel > MAX_CH) ? MAX_CH : man_sel;
    end

    // Channel/dwell/shadow update, only at frame boundaries. Manual select
    // follows man_sel even under hold; hold only freezes the shadow word
    // and, in auto mode, the rotation.
    always_comb begin
        cur_ch_d    = cur_ch_q;
        dwell_d     = dwell_q;
        shadow_d    = shadow_q;
        blank_all_d = blank_all_q;
        hold_disp_d = hold_disp_q;
        if (frame_end) begin
            hold_disp_d = hold;
            if (manual) begin
                cur_ch_d    = man_ch;
                dwell_d     = '0;
                blank_all_d = 1'b0;
            end else if (!hold) begin
                if (ch_valid == '0) begin
                    blank_all_d = 1'b1;
                    dwell_d     = '0;
                end else begin
                    blank_all_d = 1'b0;
                    if (!ch_valid[cur_ch_q] || dwell_q == DWELL_LAST) begin
                        cur_ch_d = nxt_ch;
                        dwell_d  = '0;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            if (!hold) begin
                shadow_d = ch_data[int'(cur_ch_d)*DATA_W +: DATA_W];
            end
        end
    end

    // Per-digit decode: font lookup, leading-zero blanking, guard and polarity.
    always_comb begin
        nib        = shadow_q[int'(digit)*4 +: 4];
        upper_zero = ((shadow_q >> (int'(digit)*4)) == '0);
        blank      = blank_all_q || (lz_blank && (digit != '0) && upper_zero);
        seg_on     = blank ? 7'h00 : hex_seg(nib);
        seg_d      = (SEG_ACT_LOW != 0) ? ~seg_on : seg_on;
        dp_d       = (hold_disp_q && digit == DIGIT_LAST) ? ~DP_OFF : DP_OFF;
        an_on      = (presc < GUARD_P) ? '0 : (N_DIGITS'(1) << digit);
        an_d       = (AN_ACT_LOW != 0) ? ~an_on : an_on;
    end

    // Channel selection state.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cur_ch_q    <= '0;
            dwell_q     <= '0;
            shadow_q    <= '0;
            blank_all_q <= 1'b0;
            hold_disp_q <= 1'b0;
        end else begin
            cur_ch_q    <= cur_ch_d;
            dwell_q     <= dwell_d;
            shadow_q    <= shadow_d;
            blank_all_q <= blank_all_d;
            hold_disp_q <= hold_disp_d;
        end
    end

    // Registered pin drivers, inactive during reset.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign dp     = dp_q;
    assign cur_ch = cur_ch_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: 3 channels, 4 digits, 4-clock slots with a
// 1-clock guard, 2-frame dwell, active-low pins.
module tb_seg7_scan_display;

    logic        clk;
    logic        arstn;
    logic [47:0] ch_data;
    logic [2:0]  ch_valid;
    logic        manual;
    logic [1:0]  man_sel;
    logic        hold;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  cur_ch;

    seg7_scan_display #(
        .N_CH         (3),
        .N_DIGITS     (4),
        .SCAN_DIV     (4),
        .GUARD        (1),
        .DWELL_FRAMES (2),
        .SEG_ACT_LOW  (1),
        .AN_ACT_LOW   (1)
    ) dut (
        .clk      (clk),
        .arstn    (arstn),
        .ch_data  (ch_data),
        .ch_valid (ch_valid),
        .manual   (manual),
        .man_sel  (man_sel),
        .hold     (hold),
        .lz_blank (lz_blank),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .cur_ch   (cur_ch)
    );

    // Active-low {g,f,e,d,c,b,a} patterns for 0..F.
    logic [6:0] font_l [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Expected entries are {an, seg, dp, cur_ch}.
    logic [13:0] exp_q[$];
    string       name_q[$];
    logic [13:0] imm_q[$];
    string       imm_name_q[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc;
    logic        fin_req = 1'b0;
    logic [3:0]  an_prev = 4'hF;
    logic [13:0] got, want;
    string       nm;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clock edges since the last reset release.
    always @(posedge clk or negedge arstn) begin
        if (!arstn) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(input int k, input logic [15:0] word);
        ch_data[k*16 +: 16] = word;
    endtask

    // Check of the outputs at the next falling edge.
    task automatic push_imm(input string n, input logic [3:0] a, input logic [6:0] s,
                            input logic p, input logic [1:0] ch);
        imm_q.push_back({a, s, p, ch});
        imm_name_q.push_back(n);
    endtask

    // Expected four lit digit slots of one frame.
    task automatic push_frame(input string n, input logic [15:0] word, input logic [3:0] lz_m,
                              input bit blank_all, input logic [1:0] ch, input bit hold_dp);
        logic [3:0] nibv;
        logic       off;
        logic [6:0] s;
        logic [3:0] a;
        logic       p;
        for (int d = 0; d < 4; d++) begin
            nibv = word[d*4 +: 4];
            off  = blank_all || (lz_m[d] && d != 0 && (word >> (d*4)) == 16'h0);
            s    = off ? 7'h7F : font_l[nibv];
            p    = (hold_dp && d == 3) ? 1'b0 : 1'b1;
            a    = ~(4'b0001 << d);
            exp_q.push_back({a, s, p, ch});
            name_q.push_back($sformatf("%s_d%0d", n, d));
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic compare(input string n, input logic [13:0] g, input logic [13:0] w);
        total++;
        if (g !== w) begin
            bad++;
            $display("FAIL %s: got an=%h seg=%h dp=%b ch=%0d, want an=%h seg=%h dp=%b ch=%0d",
                     n, g[13:10], g[9:3], g[2], g[1:0], w[13:10], w[9:3], w[2], w[1:0]);
        end
    endtask

    always @(negedge clk) begin
        got = {an, seg, dp, cur_ch};
        if (imm_q.size() > 0) begin
            want = imm_q.pop_front();
            nm   = imm_name_q.pop_front();
            compare(nm, got, want);
        end
        // A digit slot is presented when the anodes leave the guard state.
        if (an_prev == 4'hF && an != 4'hF && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            compare(nm, got, want);
        end
        an_prev <= an;
        if (fin_req) begin
            total++;
            if (exp_q.size() != 0 || imm_q.size() != 0) begin
                bad++;
                $display("FAIL drain: got %0d pending, want 0", exp_q.size() + imm_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        arstn    = 1'b0;
        ch_data  = '0;
        set_ch(0, 16'h1234);
        set_ch(1, 16'hABCD);
        set_ch(2, 16'h0F00);
        ch_valid = 3'b111;
        manual   = 1'b0;
        man_sel  = 2'd0;
        hold     = 1'b0;
        lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        #2 arstn = 1'b1;

        // Run into the second channel, then reset mid-slot.
        wait_cyc(37);
        arstn = 1'b0;
        push_imm("reset_async", 4'hF, 7'h7F, 1'b1, 2'd0);
        @(negedge clk);
        #2 arstn = 1'b1;

        // Guard cycle right after release, then the reset-state frame.
        push_imm("post_rst_guard", 4'hF, 7'h40, 1'b1, 2'd0);
        push_frame("f0_reset", 16'h0000, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Auto rotation, 32 clocks per channel.
        wait_cyc(16);  push_frame("f1_ch0", 16'h1234, 4'b0000, 1'b0, 2'd0, 1'b0);
        wait_cyc(32);  push_frame("f2_ch1", 16'hABCD, 4'b0000, 1'b0, 2'd1, 1'b0);
        wait_cyc(64);  push_frame("f4_ch2", 16'h0F00, 4'b0000, 1'b0, 2'd2, 1'b0);
        wait_cyc(96);  push_frame("f6_ch0", 16'h1234, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Skip invalid channel 1.
        wait_cyc(101); ch_valid = 3'b101;
        wait_cyc(128); push_frame("f8_skip_ch2", 16'h0F00, 4'b0000, 1'b0, 2'd2, 1'b0);
        wait_cyc(160); push_frame("f10_skip_ch0", 16'h1234, 4'b0000, 1'b0, 2'd0, 1'b0);

        // No valid channel: blank, channel frozen.
        wait_cyc(165); ch_valid = 3'b000;
        wait_cyc(176); push_frame("f11_none", 16'h1234, 4'b0000, 1'b1, 2'd0, 1'b0);
        wait_cyc(192); push_frame("f12_none", 16'h1234, 4'b0000, 1'b1, 2'd0, 1'b0);
        wait_cyc(197); ch_valid = 3'b111;
        wait_cyc(208); push_frame("f13_back", 16'h1234, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Hold: data change ignored, rotation frozen, dp on digit 3.
        wait_cyc(213); hold = 1'b1; set_ch(0, 16'h5678);
        wait_cyc(224); push_frame("f14_hold", 16'h1234, 4'b0000, 1'b0, 2'd0, 1'b1);
        wait_cyc(240); push_frame("f15_hold", 16'h1234, 4'b0000, 1'b0, 2'd0, 1'b1);
        wait_cyc(245); hold = 1'b0;
        wait_cyc(256); push_frame("f16_unhold", 16'hABCD, 4'b0000, 1'b0, 2'd1, 1'b0);

        // Manual mode asserted mid-frame: takes effect at the frame end.
        wait_cyc(260); manual = 1'b1; man_sel = 2'd2;
        wait_cyc(272); push_frame("f17_man2", 16'h0F00, 4'b0000, 1'b0, 2'd2, 1'b0);
        wait_cyc(277); man_sel = 2'd0; ch_valid = 3'b000;
        wait_cyc(288); push_frame("f18_man0", 16'h5678, 4'b0000, 1'b0, 2'd0, 1'b0);
        wait_cyc(293); man_sel = 2'd3;
        wait_cyc(304); push_frame("f19_man3", 16'h0F00, 4'b0000, 1'b0, 2'd2, 1'b0);

        // Leading-zero blanking; lz_blank acts on the next digit output.
        wait_cyc(309); man_sel = 2'd0; set_ch(0, 16'h0007);
        wait_cyc(320); lz_blank = 1'b1;
        push_frame("f20_lz7", 16'h0007, 4'b1111, 1'b0, 2'd0, 1'b0);
        wait_cyc(325); set_ch(0, 16'h0000);
        wait_cyc(336); push_frame("f21_lz0", 16'h0000, 4'b0011, 1'b0, 2'd0, 1'b0);
        wait_cyc(344); lz_blank = 1'b0;

        // Guard: one all-off clock at the start of the digit 0 slot.
        wait_cyc(353); push_imm("guard_c0", 4'hF, 7'h40, 1'b1, 2'd0);
        wait_cyc(354); push_imm("guard_c1", 4'hE, 7'h40, 1'b1, 2'd0);
        wait_cyc(355); push_imm("guard_c2", 4'hE, 7'h40, 1'b1, 2'd0);
        wait_cyc(356); push_imm("guard_c3", 4'hE, 7'h40, 1'b1, 2'd0);

        for (int i = 0; i < 100 && (exp_q.size() != 0 || imm_q.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        fin_req = 1'b1;
    end

endmodule
